// File: rtl/mem_stage_hs.sv
// MEM stage for a variable-latency data memory: req/gnt/rvalid handshake, pipeline stall,
// store lane steering, load alignment/extension, misalign/region/conflict/timeout checks.
module mem_stage_hs #(
  parameter logic [31:0] DMEM_BASE   = 32'h0010_0000,
  parameter int unsigned REGION_BITS = 12,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID_EM,
  input  logic [1:0]  MemWrite_EM,
  input  logic [1:0]  MemRead_EM,
  input  logic        DMSE_EM,
  input  logic [31:0] ALU_VAL_EM,
  input  logic [31:0] STORE_VAL_EM,
  output logic        STALL_M,
  output logic        MEM_VALID_M,
  output logic [31:0] MEM_DATA_M,
  output logic        EXC_MISALIGN_M,
  output logic        EXC_FAULT_M,
  output logic [31:0] EXC_ADDR_M,
  output logic        DREQ,
  output logic        DWE,
  output logic [29:0] DADDR,
  output logic [31:0] DWDATA,
  output logic [3:0]  DWSTB,
  input  logic        DGNT,
  input  logic        DRVALID,
  input  logic [31:0] DRDATA
);

  localparam int unsigned REGION_LSB = 32 - REGION_BITS;
  localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_width;
  logic        r_se;
  logic        r_mem_valid;
  logic        r_to_fault;

  logic        w_access;
  logic [1:0]  w_width;
  logic        w_misalign;
  logic        w_region_ok;
  logic        w_conflict;
  logic        w_idle;
  logic        w_exc_mis;
  logic        w_exc_flt;
  logic        w_issue;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [7:0]  w_lb;
  logic [15:0] w_lh;
  logic [31:0] w_load;
  logic        w_complete;
  logic        w_timeout;

  assign w_access    = VALID_EM & ((|MemWrite_EM) | (|MemRead_EM));
  assign w_width     = (|MemWrite_EM) ? MemWrite_EM : MemRead_EM;
  assign w_misalign  = ((w_width == 2'b10) & ALU_VAL_EM[0]) |
                       ((w_width == 2'b11) & (|ALU_VAL_EM[1:0]));
  assign w_region_ok = (ALU_VAL_EM[31:REGION_LSB] == DMEM_BASE[31:REGION_LSB]);
  assign w_conflict  = (|MemWrite_EM) & (|MemRead_EM);

  // RST gates the combinational outputs so a held EX/MEM access cannot stall during reset
  assign w_idle    = (r_state == S_IDLE) & ~RST;
  assign w_exc_mis = w_idle & w_access & w_misalign;
  assign w_exc_flt = w_idle & w_access & ~w_misalign & (~w_region_ok | w_conflict);
  assign w_issue   = w_idle & w_access & ~w_misalign & w_region_ok & ~w_conflict;

  always_comb begin
    w_strb  = '0;
    w_wdata = '0;
    case (MemWrite_EM)
      2'b01: begin
        w_strb  = 4'b0001 << ALU_VAL_EM[1:0];
        w_wdata = {4{STORE_VAL_EM[7:0]}};
      end
      2'b10: begin
        w_strb  = 4'b0011 << {ALU_VAL_EM[1], 1'b0};
        w_wdata = {2{STORE_VAL_EM[15:0]}};
      end
      2'b11: begin
        w_strb  = 4'b1111;
        w_wdata = STORE_VAL_EM;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lb = DRDATA[{r_addr[1:0], 3'b000} +: 8];
    w_lh = DRDATA[{r_addr[1], 4'b0000} +: 16];
    case (r_width)
      2'b01:   w_load = {{24{r_se & w_lb[7]}}, w_lb};
      2'b10:   w_load = {{16{r_se & w_lh[15]}}, w_lh};
      default: w_load = DRDATA;
    endcase
  end

  // A granted read is not complete until DRVALID, so it can still time out in REQ
  assign w_complete = ((r_state == S_REQ) & DWE & DGNT) | ((r_state == S_WAIT) & DRVALID);
  assign w_timeout  = ((r_state == S_REQ) | (r_state == S_WAIT)) & ~w_complete &
                      (r_cnt == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_width     <= '0;
      r_se        <= 1'b0;
      r_mem_valid <= 1'b0;
      r_to_fault  <= 1'b0;
      MEM_DATA_M  <= '0;
      DREQ        <= 1'b0;
      DWE         <= 1'b0;
      DADDR       <= '0;
      DWDATA      <= '0;
      DWSTB       <= '0;
    end else begin
      r_mem_valid <= 1'b0;
      r_to_fault  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_addr  <= ALU_VAL_EM;
            r_width <= w_width;
            r_se    <= DMSE_EM;
            r_cnt   <= '0;
            DREQ    <= 1'b1;
            DWE     <= |MemWrite_EM;
            DADDR   <= ALU_VAL_EM[31:2];
            DWDATA  <= w_wdata;
            DWSTB   <= w_strb;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_timeout) begin
            DREQ       <= 1'b0;
            r_to_fault <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (DGNT) begin
              DREQ    <= 1'b0;
              r_state <= DWE ? S_DONE : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_timeout) begin
            r_to_fault <= 1'b1;
            r_state    <= S_DONE;
          end else if (DRVALID) begin
            MEM_DATA_M  <= w_load;
            r_mem_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign STALL_M        = w_issue | (r_state == S_REQ) | (r_state == S_WAIT);
  assign MEM_VALID_M    = r_mem_valid;
  assign EXC_MISALIGN_M = w_exc_mis;
  assign EXC_FAULT_M    = w_exc_flt | r_to_fault;
  assign EXC_ADDR_M     = (w_exc_mis | w_exc_flt) ? ALU_VAL_EM :
                          r_to_fault              ? r_addr     : '0;

endmodule
